// File: rtl/nmr_bstrm_pulse_engine_pkg.sv
// Shared state encodings and default widths for the NMR bitstream pulse engine.
package nmr_bstrm_pulse_engine_pkg;

    localparam int DEF_SRAM_DAT_WIDTH = 32;
    localparam int DEF_SRAM_RD_LAT    = 2;
    localparam int DEF_DATA_WIDTH     = 24;
    localparam int DEF_MUX_WIDTH      = 16;

    typedef enum logic [1:0] {
        RD_IDLE    = 2'd0,
        RD_STROBE  = 2'd1,
        RD_WAIT    = 2'd2,
        RD_CAPTURE = 2'd3
    } rd_state_e;

    typedef enum logic {
        DP_IDLE = 1'b0,
        DP_BUSY = 1'b1
    } dp_state_e;

endpackage

// File: rtl/nmr_bstrm_sram_reader.sv
// One-shot SRAM read sequencer: strobes chip-select once, waits out the read
// latency and captures the returned word. Supports read latencies of 1 to 257.
module nmr_bstrm_sram_reader
    import nmr_bstrm_pulse_engine_pkg::*;
#(
    parameter int DAT_WIDTH = DEF_SRAM_DAT_WIDTH,
    parameter int RD_LAT    = DEF_SRAM_RD_LAT
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_start,
    input  logic [DAT_WIDTH-1:0] i_rd_dat,
    output logic                 o_sys_rdy,
    output logic                 o_data_rdy,
    output logic                 o_cs,
    output logic [DAT_WIDTH-1:0] o_data
);

    // WAIT covers RD_LAT-1 cycles, so the counter starts at RD_LAT-2
    localparam logic [7:0] WAIT_LOAD = (RD_LAT > 2) ? 8'(RD_LAT - 2) : 8'd0;

    rd_state_e            r_state;
    logic [7:0]           r_wait_cnt;
    logic                 r_cs;
    logic                 r_data_rdy;
    logic                 r_sys_rdy;
    logic [DAT_WIDTH-1:0] r_data;

    // Read sequencer state machine with registered strobe, ready and data outputs
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= RD_IDLE;
            r_wait_cnt <= 8'd0;
            r_cs       <= 1'b0;
            r_data_rdy <= 1'b0;
            r_sys_rdy  <= 1'b1;
            r_data     <= '0;
        end else begin
            r_cs       <= 1'b0;
            r_data_rdy <= 1'b0;
            case (r_state)
                RD_IDLE: begin
                    if (i_start) begin
                        r_state   <= RD_STROBE;
                        r_cs      <= 1'b1;
                        r_sys_rdy <= 1'b0;
                    end else begin
                        r_sys_rdy <= 1'b1;
                    end
                end
                RD_STROBE: begin
                    if (RD_LAT > 1) begin
                        r_state    <= RD_WAIT;
                        r_wait_cnt <= WAIT_LOAD;
                    end else begin
                        r_state <= RD_CAPTURE;
                    end
                end
                RD_WAIT: begin
                    if (r_wait_cnt == 8'd0) begin
                        r_state <= RD_CAPTURE;
                    end else begin
                        r_wait_cnt <= r_wait_cnt - 8'd1;
                    end
                end
                RD_CAPTURE: begin
                    r_data     <= i_rd_dat;
                    r_data_rdy <= 1'b1;
                    r_sys_rdy  <= 1'b1;
                    r_state    <= RD_IDLE;
                end
                default: begin
                    r_state   <= RD_IDLE;
                    r_sys_rdy <= 1'b1;
                end
            endcase
        end
    end

    assign o_sys_rdy  = r_sys_rdy;
    assign o_data_rdy = r_data_rdy;
    assign o_cs       = r_cs;
    assign o_data     = r_data;

endmodule

// File: rtl/nmr_bstrm_pulse_engine.sv
// NMR bitstream pulse engine: timed output segments from a selectable source,
// alongside an independent SRAM read unit.
module nmr_bstrm_pulse_engine
    import nmr_bstrm_pulse_engine_pkg::*;
#(
    parameter int SRAM_DAT_WIDTH = DEF_SRAM_DAT_WIDTH,
    parameter int SRAM_RD_LAT    = DEF_SRAM_RD_LAT,
    parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
    parameter int MUX_WIDTH      = DEF_MUX_WIDTH
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic                      SRAM_START,
    output logic                      SRAM_SYS_RDY,
    output logic                      SRAM_DATA_RDY,
    output logic                      SRAM_CS,
    input  logic [SRAM_DAT_WIDTH-1:0] SRAM_RD_DAT,
    output logic [SRAM_DAT_WIDTH-1:0] SRAM_DATA,
    input  logic                      DPATH_START,
    output logic                      DPATH_RDY,
    output logic                      DPATH_DONE,
    input  logic [DATA_WIDTH-1:0]     DATA,
    input  logic                      PLS_POL,
    input  logic [3:0]                MUX_SEL,
    input  logic [MUX_WIDTH-2:0]      MUX_IN,
    output logic                      OUT
);

    localparam logic [DATA_WIDTH-1:0] CNT_ONE = DATA_WIDTH'(1);

    dp_state_e             r_dp_state;
    logic [DATA_WIDTH-1:0] r_cnt;
    logic [3:0]            r_sel;
    logic                  r_pol;
    logic                  r_out;
    logic                  r_rdy;
    logic                  r_done;

    // Source 0 is the latched polarity; out-of-range selects force a low output
    function automatic logic mux_pick(input logic [3:0] sel, input logic pol,
                                      input logic [MUX_WIDTH-2:0] mux_in);
        logic v;
        v = 1'b0;
        if (sel == 4'd0) begin
            v = pol;
        end else begin
            for (int i = 1; i < MUX_WIDTH; i++) begin
                v = (int'(sel) == i) ? mux_in[i-1] : v;
            end
        end
        return v;
    endfunction

    nmr_bstrm_sram_reader #(
        .DAT_WIDTH (SRAM_DAT_WIDTH),
        .RD_LAT    (SRAM_RD_LAT)
    ) u_sram_reader (
        .i_clk      (CLK),
        .i_rst      (RST),
        .i_start    (SRAM_START),
        .i_rd_dat   (SRAM_RD_DAT),
        .o_sys_rdy  (SRAM_SYS_RDY),
        .o_data_rdy (SRAM_DATA_RDY),
        .o_cs       (SRAM_CS),
        .o_data     (SRAM_DATA)
    );

    // Segment datapath: accept a request only from IDLE, count it down, pulse done
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_dp_state <= DP_IDLE;
            r_cnt      <= '0;
            r_sel      <= 4'd0;
            r_pol      <= 1'b0;
            r_out      <= 1'b0;
            r_rdy      <= 1'b1;
            r_done     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_dp_state)
                DP_IDLE: begin
                    if (DPATH_START) begin
                        r_sel      <= MUX_SEL;
                        r_pol      <= PLS_POL;
                        r_cnt      <= (DATA == '0) ? CNT_ONE : DATA;
                        r_out      <= mux_pick(MUX_SEL, PLS_POL, MUX_IN);
                        r_rdy      <= 1'b0;
                        r_dp_state <= DP_BUSY;
                    end else begin
                        r_rdy <= 1'b1;
                    end
                end
                DP_BUSY: begin
                    // External sources are resampled every busy cycle, source 0 is static
                    if (r_sel != 4'd0) begin
                        r_out <= mux_pick(r_sel, r_pol, MUX_IN);
                    end else begin
                        r_out <= r_out;
                    end
                    if (r_cnt == CNT_ONE) begin
                        r_cnt      <= '0;
                        r_rdy      <= 1'b1;
                        r_done     <= 1'b1;
                        r_dp_state <= DP_IDLE;
                    end else begin
                        r_cnt <= r_cnt - CNT_ONE;
                    end
                end
                default: begin
                    r_dp_state <= DP_IDLE;
                    r_rdy      <= 1'b1;
                end
            endcase
        end
    end

    assign DPATH_RDY  = r_rdy;
    assign DPATH_DONE = r_done;
    assign OUT        = r_out;

endmodule

// File: tb/tb_nmr_bstrm_pulse_engine.sv
// Self-checking bench: directed scenarios plus randomized traffic against a
// cycle-scheduled behavioural model of the pulse engine.
module tb_nmr_bstrm_pulse_engine;

    localparam int DW   = 32;
    localparam int LAT  = 2;
    localparam int NW   = 24;
    localparam int MUXW = 16;

    logic            CLK = 1'b0;
    logic            RST = 1'b1;
    logic            SRAM_START = 1'b0;
    logic            SRAM_SYS_RDY, SRAM_DATA_RDY, SRAM_CS;
    logic [DW-1:0]   SRAM_RD_DAT, SRAM_DATA;
    logic            DPATH_START = 1'b0;
    logic            DPATH_RDY, DPATH_DONE;
    logic [NW-1:0]   DATA = '0;
    logic            PLS_POL = 1'b0;
    logic [3:0]      MUX_SEL = 4'd0;
    logic [MUXW-2:0] MUX_IN = '0;
    logic            OUT;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // RAM model: word valid LAT cycles after the edge that samples SRAM_CS, noise otherwise
    logic [DW-1:0] ram_word = '0;
    logic [DW-1:0] noise    = 32'hDEAD_BEEF;
    logic [1:0]    cs_d     = 2'b00;
    always @(posedge CLK) cs_d <= {cs_d[0], SRAM_CS};
    assign SRAM_RD_DAT = cs_d[LAT-1] ? ram_word : noise;

    nmr_bstrm_pulse_engine #(
        .SRAM_DAT_WIDTH (DW),
        .SRAM_RD_LAT    (LAT),
        .DATA_WIDTH     (NW),
        .MUX_WIDTH      (MUXW)
    ) dut (
        .CLK           (CLK),
        .RST           (RST),
        .SRAM_START    (SRAM_START),
        .SRAM_SYS_RDY  (SRAM_SYS_RDY),
        .SRAM_DATA_RDY (SRAM_DATA_RDY),
        .SRAM_CS       (SRAM_CS),
        .SRAM_RD_DAT   (SRAM_RD_DAT),
        .SRAM_DATA     (SRAM_DATA),
        .DPATH_START   (DPATH_START),
        .DPATH_RDY     (DPATH_RDY),
        .DPATH_DONE    (DPATH_DONE),
        .DATA          (DATA),
        .PLS_POL       (PLS_POL),
        .MUX_SEL       (MUX_SEL),
        .MUX_IN        (MUX_IN),
        .OUT           (OUT)
    );

    always #5 CLK = ~CLK;

    // ---------------- behavioural model ----------------
    logic          exp_cs, exp_drdy, exp_sysrdy, exp_out, exp_rdy, exp_done;
    logic [DW-1:0] exp_data;
    bit            rd_busy;
    int            rd_cap_cyc;
    int            remaining;
    int            m_sel;
    logic          m_pol;

    function automatic logic pick(input int s, input logic p, input logic [MUXW-2:0] in);
        if (s == 0) return p;
        if (s < MUXW) return in[s-1];
        return 1'b0;
    endfunction

    always @(posedge CLK) begin
        cyc++;
        if (RST) begin
            exp_cs = 1'b0; exp_drdy = 1'b0; exp_sysrdy = 1'b1; exp_data = '0;
            exp_out = 1'b0; exp_rdy = 1'b1; exp_done = 1'b0;
            rd_busy = 1'b0; remaining = 0; m_sel = 0; m_pol = 1'b0;
        end else begin
            // reader: a read accepted at cycle k completes at cycle k+1+LAT
            exp_cs = 1'b0;
            exp_drdy = 1'b0;
            if (rd_busy && cyc == rd_cap_cyc) begin
                exp_data = SRAM_RD_DAT;
                exp_drdy = 1'b1;
                rd_busy  = 1'b0;
            end else if (!rd_busy && SRAM_START) begin
                rd_busy    = 1'b1;
                rd_cap_cyc = cyc + 1 + LAT;
                exp_cs     = 1'b1;
            end
            exp_sysrdy = !rd_busy;
            // datapath: a segment occupies max(DATA,1) cycles after acceptance
            exp_done = 1'b0;
            if (remaining > 0) begin
                if (m_sel != 0) exp_out = pick(m_sel, m_pol, MUX_IN);
                remaining--;
                if (remaining == 0) exp_done = 1'b1;
            end else if (DPATH_START) begin
                m_sel     = int'(MUX_SEL);
                m_pol     = PLS_POL;
                remaining = (DATA == '0) ? 1 : int'(DATA);
                exp_out   = pick(m_sel, m_pol, MUX_IN);
            end
            exp_rdy = (remaining == 0);
        end
    end

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    // Compare process: every output against the model on every falling edge
    always @(negedge CLK) begin
        if (cyc > 0) begin
            chk("sram_cs",    DW'(SRAM_CS),       DW'(exp_cs));
            chk("sram_drdy",  DW'(SRAM_DATA_RDY), DW'(exp_drdy));
            chk("sram_sysrdy",DW'(SRAM_SYS_RDY),  DW'(exp_sysrdy));
            chk("sram_data",  SRAM_DATA,          exp_data);
            chk("out",        DW'(OUT),           DW'(exp_out));
            chk("dpath_rdy",  DW'(DPATH_RDY),     DW'(exp_rdy));
            chk("dpath_done", DW'(DPATH_DONE),    DW'(exp_done));
        end
    end

    task automatic step();
        @(negedge CLK);
        noise = $urandom;
    endtask

    initial begin
        // reset then idle
        repeat (3) step();
        RST = 1'b0;
        step();
        chk("rst_sysrdy", DW'(SRAM_SYS_RDY), 32'd1);
        chk("rst_rdy",    DW'(DPATH_RDY),    32'd1);
        chk("rst_out",    DW'(OUT),          32'd0);
        chk("rst_data",   SRAM_DATA,         32'd0);

        // SRAM read, latency 2
        ram_word = 32'hA500_0010;
        SRAM_START = 1'b1;
        step();
        SRAM_START = 1'b0;
        chk("rd_cs_e0",  DW'(SRAM_CS), 32'd1);
        chk("rd_rdy_e0", DW'(SRAM_SYS_RDY), 32'd0);
        step();
        chk("rd_cs_e1",  DW'(SRAM_CS), 32'd0);
        chk("rd_rdy_e1", DW'(SRAM_SYS_RDY), 32'd0);
        step();
        chk("rd_drdy_e2", DW'(SRAM_DATA_RDY), 32'd0);
        chk("rd_rdy_e2",  DW'(SRAM_SYS_RDY), 32'd0);
        step();
        chk("rd_data_e3",  SRAM_DATA, 32'hA500_0010);
        chk("rd_model_e3", exp_data,  32'hA500_0010);
        chk("rd_drdy_e3",  DW'(SRAM_DATA_RDY), 32'd1);
        chk("rd_rdy_e3",   DW'(SRAM_SYS_RDY), 32'd1);
        step();
        chk("rd_drdy_e4", DW'(SRAM_DATA_RDY), 32'd0);
        chk("rd_hold_e4", SRAM_DATA, 32'hA500_0010);

        // 5-cycle segment from source 0
        DATA = 24'd5; PLS_POL = 1'b1; MUX_SEL = 4'd0; DPATH_START = 1'b1;
        step();
        DPATH_START = 1'b0;
        chk("seg5_out_e0", DW'(OUT), 32'd1);
        chk("seg5_rdy_e0", DW'(DPATH_RDY), 32'd0);
        for (int i = 1; i < 5; i++) begin
            step();
            chk("seg5_rdy_mid",  DW'(DPATH_RDY), 32'd0);
            chk("seg5_done_mid", DW'(DPATH_DONE), 32'd0);
        end
        step();
        chk("seg5_done_e5", DW'(DPATH_DONE), 32'd1);
        chk("seg5_rdy_e5",  DW'(DPATH_RDY), 32'd1);
        chk("seg5_model_e5", DW'(exp_done), 32'd1);

        // back-to-back: second start in the first ready cycle
        DATA = 24'd3; PLS_POL = 1'b0; DPATH_START = 1'b1;
        step();
        DPATH_START = 1'b0;
        chk("b2b_out_fall", DW'(OUT), 32'd0);
        chk("b2b_rdy",      DW'(DPATH_RDY), 32'd0);
        step();
        // start mid-busy and held across the ready-return edge: both ignored
        DATA = 24'd9; PLS_POL = 1'b1; DPATH_START = 1'b1;
        step();
        chk("b2b_mid_done", DW'(DPATH_DONE), 32'd0);
        step();
        DPATH_START = 1'b0;
        chk("b2b_done", DW'(DPATH_DONE), 32'd1);
        chk("b2b_rdy_back", DW'(DPATH_RDY), 32'd1);
        step();
        chk("b2b_not_accepted", DW'(DPATH_RDY), 32'd1);
        chk("b2b_out_hold",     DW'(OUT), 32'd0);

        // external source 3, zero-length segment, source toggles mid-segment
        DATA = 24'd0; MUX_SEL = 4'd3; MUX_IN = 15'h0004; DPATH_START = 1'b1;
        step();
        DPATH_START = 1'b0;
        MUX_IN = 15'h0000;
        chk("mux_out_e0", DW'(OUT), 32'd1);
        chk("mux_rdy_e0", DW'(DPATH_RDY), 32'd0);
        step();
        MUX_IN = 15'h0004;
        chk("mux_follow", DW'(OUT), 32'd0);
        chk("mux_done",   DW'(DPATH_DONE), 32'd1);
        step();
        chk("mux_idle_hold", DW'(OUT), 32'd0);

        // reset mid-segment and during SRAM wait
        DATA = 24'd10; MUX_SEL = 4'd0; PLS_POL = 1'b1; DPATH_START = 1'b1;
        ram_word = 32'h1234_5678; SRAM_START = 1'b1;
        step();
        DPATH_START = 1'b0; SRAM_START = 1'b0;
        chk("pre_rst_out", DW'(OUT), 32'd1);
        step();
        RST = 1'b1;
        step();
        RST = 1'b0;
        chk("mrst_cs",     DW'(SRAM_CS), 32'd0);
        chk("mrst_drdy",   DW'(SRAM_DATA_RDY), 32'd0);
        chk("mrst_data",   SRAM_DATA, 32'd0);
        chk("mrst_sysrdy", DW'(SRAM_SYS_RDY), 32'd1);
        chk("mrst_out",    DW'(OUT), 32'd0);
        chk("mrst_rdy",    DW'(DPATH_RDY), 32'd1);
        chk("mrst_done",   DW'(DPATH_DONE), 32'd0);
        for (int i = 0; i < 12; i++) begin
            step();
            chk("post_rst_done", DW'(DPATH_DONE), 32'd0);
            chk("post_rst_drdy", DW'(SRAM_DATA_RDY), 32'd0);
        end

        // randomized concurrent traffic
        for (int i = 0; i < 3000; i++) begin
            RST         = ($urandom_range(0, 199) == 0);
            SRAM_START  = ($urandom_range(0, 3) == 0);
            DPATH_START = ($urandom_range(0, 2) == 0);
            DATA        = 24'($urandom_range(0, 12));
            PLS_POL     = 1'($urandom);
            MUX_SEL     = 4'($urandom);
            MUX_IN      = 15'($urandom);
            ram_word    = $urandom;
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
